// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: latches, masks and routes NSRC device requests onto CP0 IP[7:4].
// Define IRQC_SYNC_EN to add a two-flop synchronizer in front of src_r.
module irq_source_ctrl #(
    parameter int NSRC = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    input  logic            sel,
    input  logic            we,
    input  logic [2:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [3:0]      irq
);

    localparam int RW = 2 * NSRC;

    logic [NSRC-1:0] src_r_d, src_r_q;
    logic [NSRC-1:0] src_rr_d, src_rr_q;
    logic [NSRC-1:0] pending_d, pending_q;
    logic [NSRC-1:0] enable_d, enable_q;
    logic [NSRC-1:0] edge_d, edge_q;
    logic [RW-1:0]   route_d, route_q;
    logic [3:0]      irq_d, irq_q;

    logic [NSRC-1:0] active;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic            wr_en;
    logic            claim_vld;
    logic [3:0]      claim_idx;
    logic            wdata_unused;

    assign wdata_unused = ^wdata;
    assign wr_en        = sel & we;

`ifdef IRQC_SYNC_EN
    logic [NSRC-1:0] sync1_d, sync1_q;
    logic [NSRC-1:0] sync2_d, sync2_q;

    always_comb begin
        sync1_d = src;
        sync2_d = sync1_q;
        src_r_d = sync2_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end
`else
    always_comb begin
        src_r_d = src;
    end
`endif

    always_comb begin
        src_rr_d = src_r_q;
        rise     = src_r_q & ~src_rr_q;
        active   = pending_q & enable_q;
    end

    // Register writes
    always_comb begin
        w1c      = '0;
        enable_d = enable_q;
        edge_d   = edge_q;
        route_d  = route_q;
        if (wr_en) begin
            case (addr)
                3'd0:    w1c      = wdata[NSRC-1:0];
                3'd1:    enable_d = wdata[NSRC-1:0];
                3'd2:    edge_d   = wdata[NSRC-1:0];
                3'd3:    route_d  = wdata[RW-1:0];
                default: ;
            endcase
        end
    end

    // Level sources track src_r; edge sources latch until W1C, set beats clear
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NSRC; i++) begin
            if (!edge_q[i]) begin
                pending_d[i] = src_r_q[i];
            end else begin
                pending_d[i] = rise[i] | (pending_q[i] & ~w1c[i]);
            end
        end
    end

    always_comb begin
        irq_d = '0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < NSRC; i++) begin
                if (active[i] && (route_q[2*i +: 2] == 2'(k))) begin
                    irq_d[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        claim_vld = |active;
        claim_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                claim_idx = 4'(i);
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (addr)
            3'd0: rdata[NSRC-1:0] = pending_q;
            3'd1: rdata[NSRC-1:0] = enable_q;
            3'd2: rdata[NSRC-1:0] = edge_q;
            3'd3: rdata[RW-1:0]   = route_q;
            3'd4: begin
                rdata[31]  = claim_vld;
                rdata[3:0] = claim_idx;
            end
            3'd5: rdata[NSRC-1:0] = src_r_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_r_q   <= '0;
            src_rr_q  <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            route_q   <= '0;
            irq_q     <= '0;
        end else begin
            src_r_q   <= src_r_d;
            src_rr_q  <= src_rr_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            route_q   <= route_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed vector table plus hand sequences for irq_source_ctrl.
// Expected timing assumes the default build (IRQC_SYNC_EN undefined).
module tb_irq_source_ctrl;

    logic        clk;
    logic        reset;
    logic [7:0]  src;
    logic        sel;
    logic        we;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  irq;

    int n_pass;
    int n_total;

    irq_source_ctrl #(.NSRC(8)) dut (
        .clk   (clk),
        .reset (reset),
        .src   (src),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] wdata;
        logic [7:0]  src;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_irq;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        sel   = 1'b1;
        we    = 1'b1;
        addr  = a;
        wdata = d;
        cyc();
        we    = 1'b0;
        sel   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp,
                      input string nm);
        sel  = 1'b1;
        we   = 1'b0;
        addr = a;
        #1;
        chk(nm, rdata, exp);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        src   = '0;
        addr  = '0;
        wdata = '0;
        #3;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset = 1'b1;
        sel   = 1'b0;
        we    = 1'b0;
        src   = '0;
        addr  = '0;
        wdata = '0;
        // we, addr, wdata, src, exp_rdata, exp_irq (rdata/irq seen before the edge)
        tbl[0] = '{1'b1, 3'd1, 32'h1, 8'h00, 32'h0,        4'h0};
        tbl[1] = '{1'b0, 3'd1, 32'h0, 8'h01, 32'h1,        4'h0};
        tbl[2] = '{1'b0, 3'd5, 32'h0, 8'h01, 32'h1,        4'h0};
        tbl[3] = '{1'b0, 3'd0, 32'h0, 8'h01, 32'h1,        4'h0};
        tbl[4] = '{1'b0, 3'd4, 32'h0, 8'h01, 32'h80000000, 4'h1};
        tbl[5] = '{1'b1, 3'd0, 32'h1, 8'h01, 32'h1,        4'h1};
        tbl[6] = '{1'b0, 3'd0, 32'h0, 8'h00, 32'h1,        4'h1};
        tbl[7] = '{1'b0, 3'd0, 32'h0, 8'h00, 32'h1,        4'h1};
        tbl[8] = '{1'b0, 3'd0, 32'h0, 8'h00, 32'h0,        4'h1};
        tbl[9] = '{1'b0, 3'd0, 32'h0, 8'h00, 32'h0,        4'h0};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 32'h0, $sformatf("reset_rd%0d", a));
        end
        chk("reset_irq", 32'(irq), 32'h0);

        for (int i = 0; i < 10; i++) begin
            sel   = 1'b1;
            we    = tbl[i].we;
            addr  = tbl[i].addr;
            wdata = tbl[i].wdata;
            src   = tbl[i].src;
            #1;
            chk($sformatf("lvl%0d_rdata", i), rdata, tbl[i].exp_rdata);
            chk($sformatf("lvl%0d_irq", i), 32'(irq), 32'(tbl[i].exp_irq));
            cyc();
        end
        sel = 1'b0;
        we  = 1'b0;

        do_reset();
        wr(3'd1, 32'hFFFF_FFFF);
        rd(3'd1, 32'h0000_00FF, "enable_width");
        wr(3'd3, 32'hFFFF_FFFF);
        rd(3'd3, 32'h0000_FFFF, "route_width");
        wr(3'd6, 32'h1234_5678);
        rd(3'd6, 32'h0, "unused6");
        rd(3'd7, 32'h0, "unused7");
        rd(3'd4, 32'h0, "claim_idle");

        do_reset();
        wr(3'd1, 32'h1);
        src = 8'h01;
        repeat (3) cyc();
        chk("pre_async_irq", 32'(irq), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        addr = 3'd1;
        #1;
        chk("async_enable", rdata, 32'h0);
        reset = 1'b0;
        src   = '0;
        @(negedge clk);

        do_reset();
        wr(3'd2, 32'h04);
        wr(3'd1, 32'h04);
        wr(3'd3, 32'h30);
        rd(3'd3, 32'h30, "edge_route");
        src = 8'h04;
        cyc();
        src = 8'h00;
        cyc();
        cyc();
        chk("edge_irq", 32'(irq), 32'h8);
        repeat (3) cyc();
        chk("edge_irq_hold", 32'(irq), 32'h8);
        rd(3'd0, 32'h04, "edge_pending");
        wr(3'd0, 32'h04);
        chk("edge_irq_w", 32'(irq), 32'h8);
        rd(3'd0, 32'h0, "edge_w1c");
        cyc();
        chk("edge_irq_clr", 32'(irq), 32'h0);

        src = 8'h04;
        cyc();
        src = 8'h00;
        cyc();
        rd(3'd0, 32'h04, "sim_pre");
        src = 8'h04;
        cyc();
        wr(3'd0, 32'h04);
        rd(3'd0, 32'h04, "sim_set_wins");
        wr(3'd0, 32'h04);
        rd(3'd0, 32'h00, "sim_w1c_after");

        do_reset();
        wr(3'd1, 32'h28);
        src = 8'h28;
        repeat (2) cyc();
        rd(3'd4, 32'h8000_0003, "claim_3");
        wr(3'd1, 32'h20);
        rd(3'd4, 32'h8000_0005, "claim_5");
        rd(3'd0, 32'h28, "claim_pend");

        do_reset();
        wr(3'd3, 32'h0A);
        wr(3'd1, 32'h03);
        src = 8'h03;
        repeat (3) cyc();
        chk("route_both", 32'(irq), 32'h4);
        src = 8'h01;
        repeat (3) cyc();
        chk("route_one", 32'(irq), 32'h4);
        src = 8'h00;
        repeat (3) cyc();
        chk("route_none", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/irq_source_ctrl.md
# irq_source_ctrl

Memory-mapped interrupt controller that collects up to NSRC device interrupt requests and drives the four external interrupt pins (IP[7:4]) of coprocessor 0. It latches, masks and routes each source to one CP0 line and provides a claim register for the exception handler. It sits on the data-memory bus next to the other peripherals, and its `irq` output connects directly to the CP0 `interrupts[7:4]` input.

## Interface
- `NSRC`, default 8: number of device sources, 1..16.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `src`  in  NSRC  device request lines, active-high.
- `sel`  in  1  bus select for this block.
- `we`  in  1  write strobe, qualified by `sel`.
- `addr`  in  3  word offset inside the block.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, combinational from `addr`.
- `irq`  out  4  registered request lines to CP0; bit 0 drives IP[4] and bit 3 drives IP[7].

## Operation
- Register map (word offset):
  - 0 PENDING: read/write-1-to-clear.
  - 1 ENABLE: read/write.
  - 2 EDGE: read/write. 1 = rising-edge source, 0 = level source.
  - 3 ROUTE: read/write. 2 bits per source; source i uses bits [2i+1:2i] to select the CP0 line.
  - 4 CLAIM: read-only.
  - 5 RAW: read-only; returns `src_r`.
  - 6–7: read 0; writes are ignored.
- Unused upper bits read 0, and writes to them are ignored.
- Input stage: `src_r <= src` and `src_rr <= src_r` on every clock edge.
- Level source: `pending[i] <= src_r[i]` every cycle. A W1C write has no effect on it.
- Edge source: `pending[i]` is set when `src_r[i] & ~src_rr[i]`. It is cleared by writing 1 to PENDING bit i. If a set and a clear occur on the same edge, the set wins.
- `active = pending & enable`.
- `irq[k] <= OR of active[i] over all i with ROUTE[i] == k`.
- CLAIM read returns bit 31 = (active != 0) and bits [3:0] = lowest index i with active[i]. When nothing is active it returns 0. Reading CLAIM has no side effects.
- Writing ENABLE or ROUTE never modifies PENDING.
- Changing EDGE from 0 to 1 keeps the current pending value; that bit then behaves as an edge source.
- Reset values:
  - `pending`, `enable`, `edge`, `src_r`, `src_rr` and `irq` are 0.
  - ROUTE is 0, so all sources route to IP[4].
  - `rdata` follows `addr` combinationally.

## Timing
- Register writes take effect at the clock edge where `sel & we` is high. A read in the following cycle returns the new value.
- Source to `irq` latency, with the synchronizer compiled out: `src` is high at edge E0, `src_r` is set at E0, `pending` is set at E0+1, and `irq` asserts after E0+2.
- Deassertion through W1C: a W1C at edge W clears `pending` at W, and `irq` drops after W+1 if no other active source shares the line.
- Clearing an ENABLE bit drops `irq` one edge later.
- An edge-mode source held high through reset produces one rising edge after reset (`src_rr` is 0) and sets pending at the second edge after reset release.
- Reset asserted mid-operation clears all state immediately and asynchronously. Any in-flight edge is lost.
- `irq` never glitches because it is registered.

## Configuration
- `IRQC_SYNC_EN` defined: two extra flops (reset to 0) are inserted in front of `src_r` to synchronize asynchronous device lines.
  - All source-path latencies grow by 2 cycles, to 4 cycles from the sampling edge to `irq`.
  - RAW still returns `src_r`.
- `IRQC_SYNC_EN` undefined: `src` feeds `src_r` directly with the latencies given above.
- The register map and software behaviour are identical in both builds.

## Test plan
- Reset, then read all offsets -> every read is 0 and `irq` is 4'b0000. Reset while `irq` = 4'b0001 -> `irq` goes to 0 asynchronously, before the next clock.
- Level mode: ENABLE = 0x01, ROUTE = 0, `src[0]` = 1 -> `irq` = 4'b0001 exactly 2 cycles after the sampling edge (4 with `IRQC_SYNC_EN`). W1C PENDING = 0x01 while `src` stays high -> `irq` stays 1. `src[0]` = 0 -> `irq` = 0 two cycles later.
- Edge mode: EDGE = 0x04, ENABLE = 0x04, ROUTE = 0x30 (source 2 to IP[7]), pulse `src[2]` for 1 cycle -> `irq` = 4'b1000 and stays high. W1C 0x04 -> `irq` = 0 one edge later.
- Simultaneous events: W1C of bit 2 on the same edge as a new rising edge on `src[2]` -> PENDING bit 2 remains 1.
- Claim priority: sources 5 and 3 both active -> CLAIM = 0x80000003. Clear ENABLE bit 3 -> CLAIM = 0x80000005 and PENDING bit 3 is still 1.
- Routing OR: sources 0 and 1 both routed to line 2 and active -> `irq` = 4'b0100. Clear one source -> `irq` stays 4'b0100. Clear both -> `irq` = 0.
